// File: rtl/wave_gen_multi_if.sv
// Bundle of the generator's control inputs and sample outputs.
// master drives the configuration and observes samples; slave is the generator itself.
interface wave_gen_multi_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 8,
    parameter int HOLD_W = 8
);
    logic              en;
    logic [1:0]        mode;
    logic [STEP_W-1:0] step;
    logic [WIDTH-1:0]  lo;
    logic [WIDTH-1:0]  hi;
    logic [HOLD_W-1:0] hold;
    logic [WIDTH-1:0]  out_wave;
    logic              phase_dir;
    logic              cycle_done;
    logic              cfg_err;
    logic [1:0]        active_mode;

    modport master (
        output en, mode, step, lo, hi, hold,
        input  out_wave, phase_dir, cycle_done, cfg_err, active_mode
    );

    modport slave (
        input  en, mode, step, lo, hi, hold,
        output out_wave, phase_dir, cycle_done, cfg_err, active_mode
    );
endinterface

// File: rtl/wave_gen_multi.sv
// Multi-mode waveform generator: triangle, sawtooth, square and accelerating
// triangle between programmable bounds. Configuration is shadowed and only
// re-sampled when leaving IDLE or on the edge that ends a period, so a period
// in flight is never disturbed by input changes. STEP_W must not exceed WIDTH.
module wave_gen_multi #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 8,
    parameter int HOLD_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    wave_gen_multi_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RISE    = 3'd1,
        FALL    = 3'd2,
        WRAP    = 3'd3,
        HOLD_LO = 3'd4,
        HOLD_HI = 3'd5
    } state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  out_reg, out_next;
    logic              phase_reg, phase_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;
    logic [1:0]        mode_sh_reg, mode_sh_next;
    logic [STEP_W-1:0] step_sh_reg, step_sh_next;
    logic [WIDTH-1:0]  lo_sh_reg, lo_sh_next;
    logic [WIDTH-1:0]  hi_sh_reg, hi_sh_next;
    logic [HOLD_W-1:0] hold_sh_reg, hold_sh_next;
    logic [STEP_W-1:0] inc_reg, inc_next;
    logic [HOLD_W-1:0] cnt_reg, cnt_next;

    // Datapath helpers: one extra bit so neither direction can wrap out_wave.
    logic [WIDTH:0]        inc_ext;
    logic [WIDTH:0]        sum_w;
    logic signed [WIDTH:0] diff_w;
    logic                  rise_clamp;
    logic                  fall_clamp;
    logic [STEP_W:0]       inc_acc;
    logic [STEP_W-1:0]     inc_sat;
    logic                  cfg_ok;
    logic                  sample_cfg;
    state_t                start_state;

    assign inc_ext     = {{(WIDTH + 1 - STEP_W){1'b0}}, inc_reg};
    assign sum_w       = {1'b0, out_reg} + inc_ext;
    assign diff_w      = $signed({1'b0, out_reg}) - $signed(inc_ext);
    assign rise_clamp  = (sum_w >= {1'b0, hi_sh_reg});
    assign fall_clamp  = (diff_w <= $signed({1'b0, lo_sh_reg}));
    assign inc_acc     = {1'b0, inc_reg} + {1'b0, step_sh_reg};
    assign inc_sat     = inc_acc[STEP_W] ? {STEP_W{1'b1}} : inc_acc[STEP_W-1:0];
    assign cfg_ok      = (bus.hi > bus.lo) && (bus.step != '0);
    assign start_state = (bus.mode == 2'd2) ? HOLD_LO : RISE;

    // State and datapath registers; reset wins over en.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            out_reg     <= '0;
            phase_reg   <= 1'b1;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            mode_sh_reg <= '0;
            step_sh_reg <= '0;
            lo_sh_reg   <= '0;
            hi_sh_reg   <= '0;
            hold_sh_reg <= '0;
            inc_reg     <= '0;
            cnt_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            out_reg     <= out_next;
            phase_reg   <= phase_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
            mode_sh_reg <= mode_sh_next;
            step_sh_reg <= step_sh_next;
            lo_sh_reg   <= lo_sh_next;
            hi_sh_reg   <= hi_sh_next;
            hold_sh_reg <= hold_sh_next;
            inc_reg     <= inc_next;
            cnt_reg     <= cnt_next;
        end
    end

    // Next-state and sample computation; everything holds while en is low.
    // phase_dir reports the phase of the state that produced the sample.
    always_comb begin
        state_next   = state_reg;
        out_next     = out_reg;
        phase_next   = phase_reg;
        done_next    = 1'b0;
        err_next     = err_reg;
        mode_sh_next = mode_sh_reg;
        step_sh_next = step_sh_reg;
        lo_sh_next   = lo_sh_reg;
        hi_sh_next   = hi_sh_reg;
        hold_sh_next = hold_sh_reg;
        inc_next     = inc_reg;
        cnt_next     = cnt_reg;
        sample_cfg   = 1'b0;

        if (bus.en) begin
            case (state_reg)
                IDLE: begin
                    sample_cfg = 1'b1;
                    if (cfg_ok) begin
                        out_next   = bus.lo;
                        phase_next = 1'b1;
                    end
                end
                RISE: begin
                    phase_next = 1'b1;
                    if (rise_clamp) begin
                        out_next   = hi_sh_reg;
                        inc_next   = step_sh_reg;
                        state_next = (mode_sh_reg == 2'd1) ? WRAP : FALL;
                    end else begin
                        out_next = sum_w[WIDTH-1:0];
                        if (mode_sh_reg == 2'd3) begin
                            inc_next = inc_sat;
                        end
                    end
                end
                FALL: begin
                    phase_next = 1'b0;
                    if (fall_clamp) begin
                        out_next   = lo_sh_reg;
                        done_next  = 1'b1;
                        sample_cfg = 1'b1;
                    end else begin
                        out_next = diff_w[WIDTH-1:0];
                        if (mode_sh_reg == 2'd3) begin
                            inc_next = inc_sat;
                        end
                    end
                end
                WRAP: begin
                    phase_next = 1'b0;
                    out_next   = lo_sh_reg;
                    done_next  = 1'b1;
                    sample_cfg = 1'b1;
                end
                HOLD_LO: begin
                    phase_next = 1'b1;
                    if (cnt_reg == hold_sh_reg) begin
                        out_next   = hi_sh_reg;
                        cnt_next   = '0;
                        state_next = HOLD_HI;
                    end else begin
                        out_next = lo_sh_reg;
                        cnt_next = cnt_reg + HOLD_W'(1);
                    end
                end
                HOLD_HI: begin
                    phase_next = 1'b0;
                    if (cnt_reg == hold_sh_reg) begin
                        out_next   = lo_sh_reg;
                        cnt_next   = '0;
                        done_next  = 1'b1;
                        sample_cfg = 1'b1;
                    end else begin
                        out_next = hi_sh_reg;
                        cnt_next = cnt_reg + HOLD_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase

            // Period boundary or start attempt: take a fresh copy of the inputs.
            if (sample_cfg) begin
                mode_sh_next = bus.mode;
                step_sh_next = bus.step;
                lo_sh_next   = bus.lo;
                hi_sh_next   = bus.hi;
                hold_sh_next = bus.hold;
                inc_next     = bus.step;
                cnt_next     = '0;
                err_next     = !cfg_ok;
                state_next   = cfg_ok ? start_state : IDLE;
            end
        end
    end

    assign bus.out_wave    = out_reg;
    assign bus.phase_dir   = phase_reg;
    assign bus.cycle_done  = done_reg;
    assign bus.cfg_err     = err_reg;
    assign bus.active_mode = mode_sh_reg;
endmodule
